// File: rtl/riscv_imm_pkg.sv
// Shared RV32I immediate-format definitions: format codes, field positions and
// the signed ranges each immediate format can carry.
package riscv_imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_U = 3'b010,
        IMM_B = 3'b101,
        IMM_J = 3'b110,
        IMM_R = 3'b111
    } imm_src_e;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int FUNCT7_LSB = 25;

    localparam logic signed [31:0] IS_MIN = -32'sd2048;
    localparam logic signed [31:0] IS_MAX = 32'sd2047;
    localparam logic signed [31:0] U_MIN  = -32'sd524288;
    localparam logic signed [31:0] U_MAX  = 32'sd524287;
    localparam logic signed [31:0] B_MIN  = -32'sd4096;
    localparam logic signed [31:0] B_MAX  = 32'sd4094;
    localparam logic signed [31:0] J_MIN  = -32'sd1048576;
    localparam logic signed [31:0] J_MAX  = 32'sd1048574;

    function automatic logic in_range(input logic signed [31:0] v,
                                      input logic signed [31:0] lo,
                                      input logic signed [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/imm_range_check.sv
// Flags immediates the decoder could not reproduce for the chosen format.
module imm_range_check
    import riscv_imm_pkg::*;
#(
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic [31:0] imm_i,
    input  logic [2:0]  imm_src_i,
    output logic        err_o
);

    imm_src_e           src;
    logic signed [31:0] imm_s;
    logic               err_raw;

    assign src   = imm_src_e'(imm_src_i);
    assign imm_s = signed'(imm_i);

    // U keeps imm[19:0] verbatim, so it never reports an error.
    always_comb begin
        err_raw = 1'b0;
        case (src)
            IMM_I, IMM_S: err_raw = !in_range(imm_s, IS_MIN, IS_MAX);
            IMM_U:        err_raw = 1'b0;
            IMM_B:        err_raw = !in_range(imm_s, B_MIN, B_MAX) || imm_i[0];
            IMM_J:        err_raw = !in_range(imm_s, J_MIN, J_MAX) || imm_i[0];
            IMM_R:        err_raw = 1'b0;
            default:      err_raw = 1'b1;
        endcase
    end

    assign err_o = CHECK_RANGE ? err_raw : 1'b0;

endmodule

// File: rtl/instruction_encoder.sv
// Packs opcode/register/funct fields and an immediate into an RV32I word through
// a two-stage valid/ready pipeline (check+pack register, output register).
module instruction_encoder
    import riscv_imm_pkg::*;
#(
    parameter int ERR_CNT_W   = 16,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           imm_src,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [2:0]           funct3,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          instr,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    imm_src_e              src;
    logic [31:0]           word;
    logic                  word_err;
    logic                  s1_move;

    logic                  s1_valid_q, s1_valid_d;
    logic [31:0]           s1_instr_q, s1_instr_d;
    logic                  s1_err_q,   s1_err_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           instr_q,    instr_d;
    logic                  err_q,      err_d;
    logic [ERR_CNT_W-1:0]  cnt_q,      cnt_d;

    assign src = imm_src_e'(imm_src);

    imm_range_check #(.CHECK_RANGE(CHECK_RANGE)) u_range (
        .imm_i     (imm),
        .imm_src_i (imm_src),
        .err_o     (word_err)
    );

    // Bits a format does not use for registers come from the immediate.
    always_comb begin
        word = '0;
        word[OPCODE_LSB +: 7] = opcode;
        case (src)
            IMM_I: begin
                word[31:20]            = imm[11:0];
                word[RS1_LSB +: 5]     = rs1;
                word[FUNCT3_LSB +: 3]  = funct3;
                word[RD_LSB +: 5]      = rd;
            end
            IMM_S: begin
                word[31:25]            = imm[11:5];
                word[RS2_LSB +: 5]     = rs2;
                word[RS1_LSB +: 5]     = rs1;
                word[FUNCT3_LSB +: 3]  = funct3;
                word[11:7]             = imm[4:0];
            end
            IMM_U: begin
                word[31:12]            = imm[19:0];
                word[RD_LSB +: 5]      = rd;
            end
            IMM_B: begin
                word[31]               = imm[12];
                word[30:25]            = imm[10:5];
                word[RS2_LSB +: 5]     = rs2;
                word[RS1_LSB +: 5]     = rs1;
                word[FUNCT3_LSB +: 3]  = funct3;
                word[11:8]             = imm[4:1];
                word[7]                = imm[11];
            end
            IMM_J: begin
                word[31]               = imm[20];
                word[30:21]            = imm[10:1];
                word[20]               = imm[11];
                word[19:12]            = imm[19:12];
                word[RD_LSB +: 5]      = rd;
            end
            IMM_R: begin
                word[FUNCT7_LSB +: 7]  = funct7;
                word[RS2_LSB +: 5]     = rs2;
                word[RS1_LSB +: 5]     = rs1;
                word[FUNCT3_LSB +: 3]  = funct3;
                word[RD_LSB +: 5]      = rd;
            end
            default: word = '0;
        endcase
    end

    assign s1_move  = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s1_move;

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_instr_d  = s1_instr_q;
        s1_err_d    = s1_err_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_instr_d = word;
                s1_err_d   = word_err;
            end
        end
        if (s1_move) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                instr_d = s1_instr_q;
                err_d   = s1_err_q;
                if (s1_err_q && (cnt_q != {ERR_CNT_W{1'b1}}))
                    cnt_d = cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_instr_q  <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_instr_q  <= s1_instr_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign instr     = instr_q;
    assign err       = err_q;
    assign err_count = cnt_q;

endmodule
